// File: rtl/text_term_buf_if.sv
// Character-input and VGA read-port bundle for text_term_buf.
// The master side is the keyboard/VGA client and the slave side is the terminal buffer.
interface text_term_buf_if #(
  parameter int COL_W = 7,
  parameter int ROW_W = 5
);
  logic             in_valid;
  logic [7:0]       in_ascii;
  logic             in_ready;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [7:0]       rd_ascii;

  modport master (output in_valid, in_ascii, rd_col, rd_row, input in_ready, rd_ascii);
  modport slave  (input in_valid, in_ascii, rd_col, rd_row, output in_ready, rd_ascii);
endinterface

// File: rtl/text_term_buf.sv
// Character-cell terminal buffer: cursor tracking, line wrap, backspace and
// ring-buffer scrolling, with a registered (col,row) read port for the VGA renderer.
module text_term_buf #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter int         COL_W = 7,
  parameter int         ROW_W = 5,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic              clk,
  input  logic              clrn,
  text_term_buf_if.slave    bus,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy,
  output logic [7:0]        scroll_cnt
);
  localparam int N  = COLS * ROWS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_CLEAR = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [ROW_W-1:0] top_q, top_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic [7:0]       scroll_q, scroll_d;
  logic [7:0]       rd_ascii_q;
  logic [7:0]       mem_q [N];

  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [7:0]       wdata_s;
  logic             do_nl_s;
  logic [ROW_W-1:0] cur_phys_s;
  logic [ROW_W-1:0] rd_phys_s;
  logic [7:0]       rd_data_s;

  // Screen row to physical row through the ring-buffer top offset.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] t);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    else s = s;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] pr, input logic [AW-1:0] c);
    return AW'(pr) * AW'(COLS) + c;
  endfunction

  // Next-state, cursor and RAM write-port decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    top_d      = top_q;
    clr_row_d  = clr_row_q;
    scroll_d   = scroll_q;
    we_s       = 1'b0;
    waddr_s    = '0;
    wdata_s    = BLANK;
    do_nl_s    = 1'b0;
    cur_phys_s = phys_row(cur_row_q, top_q);
    case (state_q)
      ST_INIT: begin
        we_s    = 1'b1;
        waddr_s = cnt_q;
        if (cnt_q == AW'(N-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cell_addr(clr_row_q, cnt_q);
        if (cnt_q == AW'(COLS-1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.in_valid) begin
          if ((bus.in_ascii >= 8'h20) && (bus.in_ascii <= 8'h7E)) begin
            we_s    = 1'b1;
            waddr_s = cell_addr(cur_phys_s, AW'(cur_col_q));
            wdata_s = bus.in_ascii;
            if (int'(cur_col_q) < COLS-1) cur_col_d = cur_col_q + COL_W'(1);
            else do_nl_s = 1'b1;
          end else if ((bus.in_ascii == 8'h0A) || (bus.in_ascii == 8'h0D)) begin
            do_nl_s = 1'b1;
          end else if (bus.in_ascii == 8'h08) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_W'(1);
              we_s      = 1'b1;
              waddr_s   = cell_addr(cur_phys_s, AW'(cur_col_q - COL_W'(1)));
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - ROW_W'(1);
              cur_col_d = COL_W'(COLS-1);
              we_s      = 1'b1;
              waddr_s   = cell_addr(phys_row(cur_row_q - ROW_W'(1), top_q), AW'(COLS-1));
            end else begin
              we_s = 1'b0;
            end
          end else begin
            we_s = 1'b0;
          end
        end else begin
          we_s = 1'b0;
        end
        // On the bottom row a newline scrolls: the old top row becomes the new bottom.
        if (do_nl_s) begin
          cur_col_d = '0;
          if (int'(cur_row_q) < ROWS-1) begin
            cur_row_d = cur_row_q + ROW_W'(1);
          end else begin
            top_d     = (int'(top_q) == ROWS-1) ? '0 : top_q + ROW_W'(1);
            scroll_d  = scroll_q + 8'd1;
            clr_row_d = top_q;
            cnt_d     = '0;
            state_d   = ST_CLEAR;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read-port data selection, masking cells that are being (re)initialised.
  always_comb begin
    rd_phys_s = phys_row(bus.rd_row, top_q);
    rd_data_s = BLANK;
    if ((int'(bus.rd_col) >= COLS) || (int'(bus.rd_row) >= ROWS)) rd_data_s = BLANK;
    else if (state_q == ST_INIT) rd_data_s = BLANK;
    else if ((state_q == ST_CLEAR) && (rd_phys_s == clr_row_q)) rd_data_s = BLANK;
    else rd_data_s = mem_q[cell_addr(rd_phys_s, AW'(bus.rd_col))];
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      top_q      <= '0;
      clr_row_q  <= '0;
      scroll_q   <= 8'd0;
      rd_ascii_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      top_q      <= top_d;
      clr_row_q  <= clr_row_d;
      scroll_q   <= scroll_d;
      rd_ascii_q <= rd_data_s;
    end
  end

  // Character RAM, not reset; INIT fills it after every reset.
  always_ff @(posedge clk) begin
    if (we_s) mem_q[waddr_s] <= wdata_s;
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign bus.rd_ascii = rd_ascii_q;
  assign cur_col      = cur_col_q;
  assign cur_row      = cur_row_q;
  assign scroll_cnt   = scroll_q;
endmodule

// File: tb/tb_text_term_buf.sv
// Self-checking bench for text_term_buf (4x3 screen) against a screen-coordinate
// reference model that scrolls by shifting rows.
module tb_text_term_buf;
  localparam int TC = 4;
  localparam int TR = 3;
  localparam int CW = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          busy;
  logic [7:0]    scroll_cnt;
  int            checks = 0;
  int            errors = 0;

  text_term_buf_if #(.COL_W(CW), .ROW_W(RW)) bus ();

  text_term_buf #(.COLS(TC), .ROWS(TR), .COL_W(CW), .ROW_W(RW), .BLANK(8'h20)) dut (
    .clk(clk), .clrn(clrn), .bus(bus), .cur_col(cur_col), .cur_row(cur_row),
    .busy(busy), .scroll_cnt(scroll_cnt)
  );

  always #5 clk = ~clk;

  // Reference model in screen coordinates.
  logic [7:0] m_scr [TR][TC];
  logic [2:0] m_col;
  logic [1:0] m_row;
  logic [7:0] m_scroll;
  bit         m_scrolled;

  task automatic m_reset();
    for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) m_scr[r][c] = 8'h20;
    m_col = 3'd0; m_row = 2'd0; m_scroll = 8'd0; m_scrolled = 0;
  endtask

  task automatic m_newline();
    m_col = 3'd0;
    if (m_row < 2'(TR-1)) m_row = m_row + 2'd1;
    else begin
      for (int r = 0; r < TR-1; r++) for (int c = 0; c < TC; c++) m_scr[r][c] = m_scr[r+1][c];
      for (int c = 0; c < TC; c++) m_scr[TR-1][c] = 8'h20;
      m_scroll = m_scroll + 8'd1;
      m_scrolled = 1;
    end
  endtask

  task automatic m_apply(input logic [7:0] ch);
    m_scrolled = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m_scr[m_row][m_col] = ch;
      if (m_col < 3'(TC-1)) m_col = m_col + 3'd1;
      else m_newline();
    end else if (ch == 8'h0A || ch == 8'h0D) begin
      m_newline();
    end else if (ch == 8'h08) begin
      if (m_col > 3'd0) begin
        m_col = m_col - 3'd1; m_scr[m_row][m_col] = 8'h20;
      end else if (m_row > 2'd0) begin
        m_row = m_row - 2'd1; m_col = 3'(TC-1); m_scr[m_row][m_col] = 8'h20;
      end
    end
  endtask

  // Drivers (called at a negedge, return at a negedge).
  task automatic send(input logic [7:0] ch, output bit ok);
    int n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    ok = bus.in_ready;
    if (ok) begin
      bus.in_valid = 1'b1; bus.in_ascii = ch;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      m_apply(ch);
    end
  endtask

  task automatic rd(input int col, input int row, output logic [7:0] d);
    bus.rd_col = 3'(col); bus.rd_row = 2'(row);
    @(posedge clk); @(negedge clk);
    d = bus.rd_ascii;
  endtask

  task automatic do_reset(output int n);
    clrn = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1; n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    m_reset();
  endtask

  task automatic test_reset();
    int n; logic [7:0] d;
    @(negedge clk);
    checks++;
    if ({busy, bus.in_ready, cur_col, cur_row, scroll_cnt, bus.rd_ascii} !== {1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 8'h00}) begin
      errors++; $display("FAIL reset_values: got busy=%b rdy=%b col=%0d row=%0d sc=%0d rd=%h", busy, bus.in_ready, cur_col, cur_row, scroll_cnt, bus.rd_ascii);
    end
    do_reset(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL init_len: got %0d want 12", n); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", bus.in_ready); end
    for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) begin
      rd(c, r, d); checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL init_cell(%0d,%0d): got %h want 20", c, r, d); end
    end
    rd(4, 0, d); checks++; if (d !== 8'h20) begin errors++; $display("FAIL oor_col: got %h want 20", d); end
    rd(0, 3, d); checks++; if (d !== 8'h20) begin errors++; $display("FAIL oor_row: got %h want 20", d); end
  endtask

  task automatic test_fill();
    int n; bit ok; logic [7:0] d;
    do_reset(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL fill_init: got %0d want 12", n); end
    for (int i = 0; i < 4; i++) begin
      send(8'h41 + 8'(i), ok); checks++;
      if (!ok) begin errors++; $display("FAIL fill_accept: got not-ready want ready"); end
    end
    checks++; if ({cur_col, cur_row} !== {3'd0, 2'd1}) begin errors++; $display("FAIL fill_cursor: got (%0d,%0d) want (0,1)", cur_col, cur_row); end
    for (int c = 0; c < TC; c++) begin
      rd(c, 0, d); checks++;
      if (d !== 8'h41 + 8'(c)) begin errors++; $display("FAIL fill_cell(%0d): got %h want %h", c, d, 8'h41 + 8'(c)); end
    end
  endtask

  task automatic test_scroll();
    int n; bit ok; logic [7:0] d;
    do_reset(n);
    for (int i = 0; i < 12; i++) begin
      send(8'h61 + 8'(i), ok); checks++;
      if (!ok) begin errors++; $display("FAIL scroll_accept: got not-ready want ready"); end
    end
    checks++; if ({busy, scroll_cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL scroll_state: got busy=%b sc=%0d want 1,1", busy, scroll_cnt); end
    bus.rd_col = 3'd3; bus.rd_row = 2'd2;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 1) begin
        checks++; if (bus.rd_ascii !== 8'h20) begin errors++; $display("FAIL clear_read: got %h want 20", bus.rd_ascii); end
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL clear_len: got %0d want 4", n); end
    checks++; if ({cur_col, cur_row} !== {3'd0, 2'd2}) begin errors++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,2)", cur_col, cur_row); end
    for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) begin
      rd(c, r, d); checks++;
      if (d !== m_scr[r][c]) begin errors++; $display("FAIL scroll_cell(%0d,%0d): got %h want %h", c, r, d, m_scr[r][c]); end
    end
    send(8'h31, ok); send(8'h32, ok);
    checks++; if ({cur_col, cur_row} !== {3'd2, 2'd2}) begin errors++; $display("FAIL scroll_cursor2: got (%0d,%0d) want (2,2)", cur_col, cur_row); end
  endtask

  task automatic test_backspace();
    int n; bit ok; logic [7:0] d;
    logic [7:0] seq [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h58, 8'h08, 8'h08};
    do_reset(n);
    foreach (seq[i]) send(seq[i], ok);
    checks++; if ({cur_col, cur_row} !== {3'd3, 2'd0}) begin errors++; $display("FAIL bs_cursor: got (%0d,%0d) want (3,0)", cur_col, cur_row); end
    rd(0, 1, d); checks++; if (d !== 8'h20) begin errors++; $display("FAIL bs_cell01: got %h want 20", d); end
    rd(3, 0, d); checks++; if (d !== 8'h20) begin errors++; $display("FAIL bs_cell30: got %h want 20", d); end
    rd(2, 0, d); checks++; if (d !== 8'h43) begin errors++; $display("FAIL bs_cell20: got %h want 43", d); end
  endtask

  task automatic test_noop();
    int n; bit ok; logic [7:0] d;
    do_reset(n);
    send(8'h08, ok); checks++; if (!ok) begin errors++; $display("FAIL noop_bs_accept: got not-ready want ready"); end
    send(8'h07, ok); checks++; if (!ok) begin errors++; $display("FAIL noop_bel_accept: got not-ready want ready"); end
    checks++; if ({cur_col, cur_row, scroll_cnt, bus.in_ready} !== {3'd0, 2'd0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL noop_state: got (%0d,%0d) sc=%0d rdy=%b want (0,0) 0 1", cur_col, cur_row, scroll_cnt, bus.in_ready);
    end
    for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) begin
      rd(c, r, d); checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL noop_cell(%0d,%0d): got %h want 20", c, r, d); end
    end
  endtask

  task automatic test_random();
    int n; bit ok; logic [7:0] ch, d; int k;
    do_reset(n);
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) ch = 8'($urandom_range(32, 126));
      else if (k == 6) ch = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
      else if (k <= 8) ch = 8'h08;
      else begin
        ch = 8'($urandom_range(0, 255));
        if ((ch >= 8'h20 && ch <= 8'h7E) || ch == 8'h08 || ch == 8'h0A || ch == 8'h0D) ch = 8'h7F;
      end
      send(ch, ok);
      checks++;
      if (!ok || {cur_col, cur_row, scroll_cnt, busy} !== {m_col, m_row, m_scroll, m_scrolled}) begin
        errors++; $display("FAIL rnd_state[%0d] ch=%h: got ok=%b (%0d,%0d) sc=%0d busy=%b want (%0d,%0d) sc=%0d busy=%b",
                           i, ch, ok, cur_col, cur_row, scroll_cnt, busy, m_col, m_row, m_scroll, m_scrolled);
      end
      if (m_scrolled) begin
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        checks++; if (n !== TC) begin errors++; $display("FAIL rnd_clear_len: got %0d want %0d", n, TC); end
      end
      if (i % 30 == 29) begin
        for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) begin
          rd(c, r, d); checks++;
          if (d !== m_scr[r][c]) begin errors++; $display("FAIL rnd_cell(%0d,%0d): got %h want %h", c, r, d, m_scr[r][c]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n; bit ok; logic [7:0] d;
    do_reset(n);
    for (int i = 0; i < 12; i++) send(8'h61 + 8'(i), ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy: got %b want 1", busy); end
    bus.rd_col = 3'd0; bus.rd_row = 2'd1;
    #2 clrn = 1'b0;
    #1;
    checks++;
    if ({busy, bus.in_ready, cur_col, cur_row, scroll_cnt, bus.rd_ascii} !== {1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 8'h00}) begin
      errors++; $display("FAIL async_reset: got busy=%b rdy=%b col=%0d row=%0d sc=%0d rd=%h", busy, bus.in_ready, cur_col, cur_row, scroll_cnt, bus.rd_ascii);
    end
    @(negedge clk);
    clrn = 1'b1; n = 0;
    while (busy && n < 100) begin
      @(negedge clk); n++;
      if (n == 1) begin
        checks++; if (bus.rd_ascii !== 8'h20) begin errors++; $display("FAIL init_read_mask: got %h want 20", bus.rd_ascii); end
      end
    end
    checks++; if (n !== 12) begin errors++; $display("FAIL reinit_len: got %0d want 12", n); end
    m_reset();
    for (int r = 0; r < TR; r++) for (int c = 0; c < TC; c++) begin
      rd(c, r, d); checks++;
      if (d !== 8'h20) begin errors++; $display("FAIL reinit_cell(%0d,%0d): got %h want 20", c, r, d); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_ascii = 8'h00; bus.rd_col = 3'd0; bus.rd_row = 2'd0;
    test_reset();
    test_fill();
    test_scroll();
    test_backspace();
    test_noop();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
